mem_port_scheduler: RTL and testbench

Shares one single-port synchronous SRAM between NUM_REQ requesters using round-robin arbitration with a bounded burst hold. Each requester uses a valid/ready command handshake. The block drives registered memory commands and routes read data back to the issuing requester through a tag pipeline matched to the fixed memory read latency. It sits between the client ports and the memory macro, replacing the bare grant-only arbiter.

---
 rtl/mem_sched_pkg.sv | 29 ++
 rtl/mem_port_scheduler_rr_pick.sv | 47 ++++
 rtl/mem_port_scheduler.sv | 161 ++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg
// Shared definitions for the memory port scheduler:
//   BURST_W        width of the burst counter (debug port and saturation logic)
//   sched_state_t  scheduler state, IDLE when no burst is running, HOLD otherwise
//   id_width()     width of a requester index for a given requester count
//   MPS_FIELD      slice macro for packed per-requester fields
`ifndef MEM_SCHED_PKG_SV
`define MEM_SCHED_PKG_SV

// Element idx of width w inside a packed per-requester vector.
`define MPS_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]

package mem_sched_pkg;

    localparam int BURST_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_t;

    // A single requester still needs a 1-bit index.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/mem_port_scheduler_rr_pick.sv
// rr_pick
// Combinational rotating-priority picker.
//   req    request vector
//   start  index that has the highest priority this cycle
//   grant  one-hot grant of the first requester at or after start (wrapping)
//   found  high when any request is set
module rr_pick
    import mem_sched_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          found
);

    logic [N-1:0] upper;

    // Requests at or above the start index are searched first; the
    // plain request vector then covers the wrapped-around part.
    always_comb begin
        upper = '0;
        for (int k = 0; k < N; k++) begin
            upper[k] = req[k] && (k >= int'(start));
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && upper[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler
// Shares one single-port synchronous SRAM between NUM_REQ requesters.
// Round-robin arbitration with a bounded burst hold, registered memory
// commands and read-data routing through a tag pipeline that matches the
// fixed memory read latency.
// Ports:
//   clk, reset                clock and asynchronous active-high reset
//   req_valid/req_ready       per-requester command handshake
//   req_we/req_addr/req_wdata per-requester command fields (packed)
//   rsp_valid/rsp_rdata       one-hot read return strobe and shared data bus
//   mem_busy                  memory stall, blocks new accepts
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  SRAM interface
//   owner_id/burst_cnt        debug view of arbitration state
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int ADDR_W    = 10,
    parameter  int DATA_W    = 32,
    parameter  int RD_LAT    = 2,
    parameter  int BURST_MAX = 4,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    input  logic                      mem_busy,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [ID_W-1:0]           owner_id,
    output logic [BURST_W-1:0]        burst_cnt
);

    sched_state_t         state;
    logic [ID_W-1:0]      start_idx;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      cmd_id;
    logic [NUM_REQ-1:0]   rr_grant;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 rr_found;
    logic                 hold_win;
    logic                 accept;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 pipe_vld [RD_LAT];
    logic [ID_W-1:0]      pipe_id  [RD_LAT];

    // Rotation starts just after the last owner so every requester gets a turn.
    assign start_idx = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + ID_W'(1);

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .start (start_idx),
        .grant (rr_grant),
        .found (rr_found)
    );

    assign hold_win = (state == ST_HOLD) && req_valid[owner_id]
                      && (burst_cnt < BURST_W'(BURST_MAX));

    always_comb begin
        win_onehot = '0;
        if (hold_win) begin
            win_onehot[owner_id] = 1'b1;
        end else if (rr_found) begin
            win_onehot = rr_grant;
        end
    end

    // Ready is also masked during reset so nothing looks accepted while the
    // arbitration state is being cleared.
    assign req_ready = (reset || mem_busy) ? '0 : win_onehot;
    assign accept    = |(req_valid & req_ready);

    // Select the winner's index and command fields.
    always_comb begin
        win_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_onehot[k]) begin
                win_idx   = ID_W'(k);
                sel_we    = req_we[k];
                sel_addr  = `MPS_FIELD(req_addr, k, ADDR_W);
                sel_wdata = `MPS_FIELD(req_wdata, k, DATA_W);
            end
        end
    end

    // Arbitration state, registered memory command and read tag pipeline.
    // The tag pipeline is fed from the registered command, so its last stage
    // lines up with mem_rdata RD_LAT cycles after the mem_en cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner_id  <= ID_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cmd_id    <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_id[k]  <= '0;
            end
        end else begin
            mem_en <= accept;
            mem_we <= accept & sel_we;
            if (accept) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                cmd_id    <= win_idx;
            end

            // Busy freezes ownership; an idle unstalled cycle ends the burst.
            if (accept) begin
                state <= ST_HOLD;
                if (win_idx == owner_id) begin
                    if (burst_cnt < BURST_W'(BURST_MAX)) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end else begin
                    owner_id  <= win_idx;
                    burst_cnt <= BURST_W'(1);
                end
            end else if (!mem_busy) begin
                state     <= ST_IDLE;
                burst_cnt <= '0;
            end

            pipe_vld[0] <= mem_en & ~mem_we;
            pipe_id[0]  <= cmd_id;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pipe_vld[RD_LAT-1]) begin
            rsp_valid[pipe_id[RD_LAT-1]] = 1'b1;
            rsp_rdata                    = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler
// Directed self-checking bench for mem_port_scheduler with NUM_REQ=3,
// RD_LAT=2, BURST_MAX=4. The memory model returns addr+0x100 RD_LAT cycles
// after a read command.
module tb_mem_port_scheduler;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int BURST_MAX = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      mem_busy;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [1:0]                owner_id;
    logic [3:0]                burst_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_busy  (mem_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner_id  (owner_id),
        .burst_cnt (burst_cnt)
    );

    // SRAM model: read data for a command appears RD_LAT cycles after its mem_en cycle.
    logic              hist_vld  [RD_LAT] = '{default: 1'b0};
    logic [ADDR_W-1:0] hist_addr [RD_LAT] = '{default: '0};

    always @(posedge clk) begin
        hist_vld[0]  <= mem_en & ~mem_we;
        hist_addr[0] <= mem_addr;
        for (int k = 1; k < RD_LAT; k++) begin
            hist_vld[k]  <= hist_vld[k-1];
            hist_addr[k] <= hist_addr[k-1];
        end
    end

    assign mem_rdata = hist_vld[RD_LAT-1] ? (32'(hist_addr[RD_LAT-1]) + 32'h100)
                                          : 32'hBAD0_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ-1:0] we,
                                 input logic               busy);
        req_valid = valid;
        req_we    = we;
        mem_busy  = busy;
        #1;
    endtask

    task automatic setPort(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int grantSeq [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int burstSeq [13] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 1};

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_busy  = 1'b0;

        // Reset state, with requests already pending.
        step();
        step();
        applyStimulus(3'b111, 3'b111, 1'b0);
        checkOutput("rst_ready",     req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_mem_en",    mem_en,    0);
        checkOutput("rst_mem_we",    mem_we,    0);
        checkOutput("rst_mem_addr",  mem_addr,  0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_owner",     owner_id,  2);
        checkOutput("rst_burst",     burst_cnt, 0);

        // Burst limit: all three write continuously.
        for (int i = 0; i < NUM_REQ; i++) begin
            setPort(i, ADDR_W'(10'h040 + i), 32'hA0 + 32'(i));
        end
        reset = 1'b0;
        #1;
        for (int n = 0; n < 13; n++) begin
            checkOutput("burst_ready", req_ready, 64'd1 << grantSeq[n]);
            step();
            checkOutput("burst_owner", owner_id,  64'(grantSeq[n]));
            checkOutput("burst_cnt",   burst_cnt, 64'(burstSeq[n]));
            checkOutput("burst_addr",  mem_addr,  64'h40 + 64'(grantSeq[n]));
            checkOutput("burst_mem_en", mem_en,   1);
        end
        applyStimulus(3'b000, 3'b000, 1'b0);
        step();
        checkOutput("idle_burst",  burst_cnt, 0);
        checkOutput("idle_owner",  owner_id,  0);
        checkOutput("idle_mem_en", mem_en,    0);

        // Early release: requester 1 single write.
        setPort(1, 10'h005, 32'hDEADBEEF);
        applyStimulus(3'b010, 3'b010, 1'b0);
        checkOutput("wr_ready", req_ready, 3'b010);
        step();
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("wr_mem_en",    mem_en,    1);
        checkOutput("wr_mem_we",    mem_we,    1);
        checkOutput("wr_mem_addr",  mem_addr,  10'h005);
        checkOutput("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("wr_owner",     owner_id,  1);
        checkOutput("wr_burst",     burst_cnt, 1);
        step();
        checkOutput("wr_idle_burst", burst_cnt, 0);
        checkOutput("wr_idle_en",    mem_en,    0);

        // Read routing: requester 2 then requester 0 back-to-back.
        setPort(2, 10'h010, 32'h0);
        applyStimulus(3'b100, 3'b000, 1'b0);
        checkOutput("rd_ready2", req_ready, 3'b100);
        step();
        setPort(0, 10'h011, 32'h0);
        applyStimulus(3'b001, 3'b000, 1'b0);
        checkOutput("rd_ready0",   req_ready, 3'b001);
        checkOutput("rd_mem_addr2", mem_addr, 10'h010);
        checkOutput("rd_mem_we2",  mem_we,    0);
        step();
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("rd_mem_addr0", mem_addr, 10'h011);
        checkOutput("rd_rsp_early", rsp_valid, 0);
        step();
        checkOutput("rd_rsp_valid2", rsp_valid, 3'b100);
        checkOutput("rd_rsp_data2",  rsp_rdata, 32'h110);
        step();
        checkOutput("rd_rsp_valid0", rsp_valid, 3'b001);
        checkOutput("rd_rsp_data0",  rsp_rdata, 32'h111);
        step();
        checkOutput("rd_rsp_done",  rsp_valid, 0);
        checkOutput("rd_rsp_zero",  rsp_rdata, 0);

        // Stall: read by requester 1, then three busy cycles.
        setPort(1, 10'h020, 32'h0);
        applyStimulus(3'b010, 3'b000, 1'b0);
        checkOutput("st_ready_pre", req_ready, 3'b010);
        step();
        applyStimulus(3'b111, 3'b111, 1'b1);
        checkOutput("st_ready_busy", req_ready, 0);
        step();
        checkOutput("st_owner1",  owner_id,  1);
        checkOutput("st_burst1",  burst_cnt, 1);
        checkOutput("st_mem_en",  mem_en,    0);
        checkOutput("st_rsp_pre", rsp_valid, 0);
        step();
        checkOutput("st_rsp_valid", rsp_valid, 3'b010);
        checkOutput("st_rsp_data",  rsp_rdata, 32'h120);
        checkOutput("st_ready2",    req_ready, 0);
        checkOutput("st_burst2",    burst_cnt, 1);
        step();
        checkOutput("st_owner3", owner_id,  1);
        checkOutput("st_burst3", burst_cnt, 1);
        applyStimulus(3'b111, 3'b111, 1'b0);
        checkOutput("st_ready_resume", req_ready, 3'b010);
        step();
        checkOutput("st_burst_resume", burst_cnt, 2);
        checkOutput("st_mem_we_resume", mem_we,   1);

        // Reset with two reads in flight.
        setPort(0, 10'h030, 32'h0);
        applyStimulus(3'b001, 3'b000, 1'b0);
        checkOutput("rr_ready_a", req_ready, 3'b001);
        step();
        setPort(0, 10'h031, 32'h0);
        #1;
        checkOutput("rr_ready_b", req_ready, 3'b001);
        step();
        applyStimulus(3'b000, 3'b000, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rr_mem_en",  mem_en,    0);
        checkOutput("rr_owner",   owner_id,  2);
        checkOutput("rr_burst",   burst_cnt, 0);
        checkOutput("rr_mem_addr", mem_addr, 0);
        step();
        checkOutput("rr_rsp_a", rsp_valid, 0);
        reset = 1'b0;
        #1;
        step();
        checkOutput("rr_rsp_b",   rsp_valid, 0);
        checkOutput("rr_mem_en_b", mem_en,   0);
        step();
        checkOutput("rr_rsp_c",   rsp_valid, 0);
        checkOutput("rr_mem_en_c", mem_en,   0);

        // First grant after reset goes to requester 0.
        applyStimulus(3'b111, 3'b111, 1'b0);
        checkOutput("post_ready", req_ready, 3'b001);
        step();
        checkOutput("post_owner",  owner_id,  0);
        checkOutput("post_burst",  burst_cnt, 1);
        checkOutput("post_mem_en", mem_en,    1);

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
